// File: rtl/shift_reg.sv
// shift_reg: parameterised shift register with parallel load, serial in/out,
// direction control and logical / arithmetic / rotate fill modes.
// Each bit is its own cell; the top computes the shared fill bit and wires
// neighbours so every cell only chooses between its left and right source.

module shift_reg_cell #(
  parameter logic RST_BIT = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic load,
  input  logic par_bit,
  input  logic shift,
  input  logic dir,
  input  logic left_src,   // value this bit takes on a left shift
  input  logic right_src,  // value this bit takes on a right shift
  output logic q
);

  // One bit of state: clr beats load beats shift beats hold
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)     q <= RST_BIT;
    else if (clr)   q <= 1'b0;
    else if (load)  q <= par_bit;
    else if (shift) q <= dir ? right_src : left_src;
  end

endmodule

module shift_reg #(
  parameter int               WIDTH       = 8,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             load,
  input  logic [WIDTH-1:0] par_in,
  input  logic             en,
  input  logic             dir,
  input  logic [1:0]       mode,
  input  logic             ser_in,
  output logic [WIDTH-1:0] par_out,
  output logic             ser_out
);

  localparam logic [1:0] MODE_LOG = 2'b00;
  localparam logic [1:0] MODE_ARI = 2'b01;
  localparam logic [1:0] MODE_ROT = 2'b10;

  logic [WIDTH-1:0] q;
  logic             fill;
  logic             shift;
  logic             out_bit;

  // The reserved mode encoding freezes the register even with en high
  assign shift   = en & (mode != 2'b11);
  // Bit that leaves the register on the next shift in the current direction
  assign out_bit = dir ? q[0] : q[WIDTH-1];

  // Fill bit entering the vacated end; ser_in only matters in logical mode
  always_comb begin
    fill = 1'b0;
    case (mode)
      MODE_LOG: fill = ser_in;
      MODE_ARI: fill = dir ? q[WIDTH-1] : 1'b0;
      MODE_ROT: fill = out_bit;
      default:  fill = 1'b0;
    endcase
  end

  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
    logic lsrc;
    logic rsrc;
    if (gi == 0) begin : g_lo
      assign lsrc = fill;
    end else begin : g_lo
      assign lsrc = q[gi-1];
    end
    if (gi == WIDTH-1) begin : g_hi
      assign rsrc = fill;
    end else begin : g_hi
      assign rsrc = q[gi+1];
    end
    shift_reg_cell #(.RST_BIT(RESET_VALUE[gi])) u_cell (
      .clk       (clk),
      .rst_n     (rst_n),
      .clr       (clr),
      .load      (load),
      .par_bit   (par_in[gi]),
      .shift     (shift),
      .dir       (dir),
      .left_src  (lsrc),
      .right_src (rsrc),
      .q         (q[gi])
    );
  end

  assign par_out = q;
  assign ser_out = out_bit;

endmodule

// File: tb/tb_shift_reg.sv
// tb_shift_reg: table-driven directed vectors, hand-written multi-cycle
// sequences and a randomized run against a behavioural model.

module tb_shift_reg;

  localparam int         W  = 8;
  localparam logic [7:0] RV = 8'hA5;

  logic         clk = 1'b0;
  logic         rst_n, clr, load, en, dir, ser_in;
  logic [W-1:0] par_in;
  logic [1:0]   mode;
  logic [W-1:0] par_out;
  logic         ser_out;

  int total = 0;
  int bad   = 0;

  shift_reg #(.WIDTH(W), .RESET_VALUE(RV)) dut (
    .clk(clk), .rst_n(rst_n), .clr(clr), .load(load), .par_in(par_in),
    .en(en), .dir(dir), .mode(mode), .ser_in(ser_in),
    .par_out(par_out), .ser_out(ser_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       clr, load, en, dir, ser_in;
    logic [1:0] mode;
    logic [7:0] par_in;
    logic [7:0] exp_q;
    logic       exp_ser;
  } vec_t;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic c, input logic l, input logic [7:0] p, input logic e,
                       input logic d, input logic [1:0] m, input logic s);
    clr = c; load = l; par_in = p; en = e; dir = d; mode = m; ser_in = s;
  endtask

  // Apply inputs, clock once, sample 1 time unit after the edge
  task automatic step(input logic c, input logic l, input logic [7:0] p, input logic e,
                      input logic d, input logic [1:0] m, input logic s);
    drive(c, l, p, e, d, m, s);
    @(posedge clk);
    #1;
  endtask

  // Behavioural model: what the register holds after one edge
  function automatic logic [7:0] model(input logic [7:0] q, input logic c, input logic l,
                                       input logic [7:0] p, input logic e, input logic d,
                                       input logic [1:0] m, input logic s);
    logic [7:0] r;
    int         fill;
    if (c) return 8'h00;
    if (l) return p;
    if (!e || m == 2'b11) return q;
    if (!d) begin
      fill = (m == 2'b00) ? int'(s) : (m == 2'b01) ? 0 : int'(q >= 8'h80);
      r = 8'((int'(q) * 2) % 256 + fill);
    end else begin
      fill = (m == 2'b00) ? int'(s) : (m == 2'b01) ? int'(q >= 8'h80) : int'(q % 2);
      r = 8'(int'(q) / 2 + fill * 128);
    end
    return r;
  endfunction

  vec_t       tbl[20];
  logic [7:0] mq, sv, first;
  logic       eser;

  initial begin
    //            clr load en dir ser mode   par    exp   ser
    tbl[0]  = '{1'b0,1'b1,1'b0,1'b0,1'b0,2'b00,8'h81,8'h81,1'b1};
    tbl[1]  = '{1'b0,1'b0,1'b1,1'b0,1'b1,2'b00,8'hFF,8'h03,1'b0};
    tbl[2]  = '{1'b0,1'b0,1'b1,1'b0,1'b1,2'b00,8'h00,8'h07,1'b0};
    tbl[3]  = '{1'b0,1'b0,1'b1,1'b0,1'b1,2'b00,8'h00,8'h0F,1'b0};
    tbl[4]  = '{1'b0,1'b1,1'b0,1'b1,1'b0,2'b01,8'h90,8'h90,1'b0};
    tbl[5]  = '{1'b0,1'b0,1'b1,1'b1,1'b1,2'b01,8'h00,8'hC8,1'b0};
    tbl[6]  = '{1'b0,1'b0,1'b1,1'b1,1'b1,2'b01,8'h00,8'hE4,1'b0};
    tbl[7]  = '{1'b0,1'b0,1'b1,1'b1,1'b0,2'b01,8'h00,8'hF2,1'b0};
    tbl[8]  = '{1'b0,1'b0,1'b1,1'b1,1'b0,2'b01,8'h00,8'hF9,1'b1};
    tbl[9]  = '{1'b0,1'b1,1'b0,1'b1,1'b0,2'b01,8'h40,8'h40,1'b0};
    tbl[10] = '{1'b0,1'b0,1'b1,1'b1,1'b0,2'b01,8'h00,8'h20,1'b0};
    tbl[11] = '{1'b0,1'b0,1'b1,1'b1,1'b0,2'b01,8'h00,8'h10,1'b0};
    tbl[12] = '{1'b0,1'b1,1'b0,1'b0,1'b0,2'b10,8'h96,8'h96,1'b1};
    tbl[13] = '{1'b0,1'b0,1'b1,1'b0,1'b0,2'b10,8'h00,8'h2D,1'b0};
    tbl[14] = '{1'b0,1'b1,1'b1,1'b0,1'b0,2'b00,8'h3C,8'h3C,1'b0};
    tbl[15] = '{1'b1,1'b1,1'b1,1'b0,1'b1,2'b00,8'hFF,8'h00,1'b0};
    tbl[16] = '{1'b0,1'b1,1'b0,1'b0,1'b0,2'b00,8'h5A,8'h5A,1'b0};
    tbl[17] = '{1'b0,1'b0,1'b1,1'b0,1'b1,2'b11,8'hFF,8'h5A,1'b0};
    tbl[18] = '{1'b0,1'b0,1'b1,1'b1,1'b1,2'b00,8'h00,8'hAD,1'b1};
    tbl[19] = '{1'b0,1'b0,1'b1,1'b0,1'b1,2'b01,8'h00,8'h5A,1'b0};

    // Reset asserted before any edge: value appears without a clock
    drive(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 2'b00, 1'b0);
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    #1 check("reset_immediate", par_out, RV);
    repeat (3) @(posedge clk);
    #1 check("reset_held", par_out, RV);
    rst_n = 1'b1;
    step(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 2'b00, 1'b0);
    check("release_hold", par_out, RV);
    check("release_ser", {7'd0, ser_out}, 8'h01);

    // Directed table
    for (int i = 0; i < 20; i++) begin
      step(tbl[i].clr, tbl[i].load, tbl[i].par_in, tbl[i].en, tbl[i].dir, tbl[i].mode, tbl[i].ser_in);
      check($sformatf("vec%0d_q", i), par_out, tbl[i].exp_q);
      check($sformatf("vec%0d_ser", i), {7'd0, ser_out}, {7'd0, tbl[i].exp_ser});
    end

    // Rotate a full width in each direction
    for (int d = 0; d < 2; d++) begin
      step(1'b0, 1'b1, 8'h96, 1'b0, 1'(d), 2'b10, 1'b0);
      for (int k = 0; k < W; k++) begin
        step(1'b0, 1'b0, 8'h00, 1'b1, 1'(d), 2'b10, 1'b1);
        if (k == 0) first = par_out;
      end
      check($sformatf("rot_dir%0d_first", d), first, d ? 8'h4B : 8'h2D);
      check($sformatf("rot_dir%0d_final", d), par_out, 8'h96);
    end

    // Logical shifts with ser_in=0 empty the register
    step(1'b0, 1'b1, 8'hFF, 1'b0, 1'b0, 2'b00, 1'b0);
    repeat (W) step(1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 2'b00, 1'b0);
    check("logic_empty", par_out, 8'h00);

    // Arithmetic right saturation, negative then positive
    step(1'b0, 1'b1, 8'h80, 1'b0, 1'b1, 2'b01, 1'b0);
    repeat (W + 2) step(1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 2'b01, 1'b0);
    check("ari_sat_neg", par_out, 8'hFF);
    step(1'b0, 1'b1, 8'h7F, 1'b0, 1'b1, 2'b01, 1'b1);
    repeat (W + 2) step(1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 2'b01, 1'b1);
    check("ari_sat_pos", par_out, 8'h00);

    // Async reset in the middle of continuous shifting
    step(1'b0, 1'b1, 8'h3C, 1'b0, 1'b0, 2'b00, 1'b1);
    step(1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 2'b00, 1'b1);
    #2 rst_n = 1'b0;
    #1 check("async_mid_shift", par_out, RV);
    @(posedge clk); #1;
    check("async_hold_in_reset", par_out, RV);
    @(negedge clk) rst_n = 1'b1;

    // Randomized run against the model
    mq = RV;
    for (int n = 0; n < 400; n++) begin
      logic       c, l, e, d, s;
      logic [1:0] m;
      logic [7:0] p;
      c = ($urandom_range(0, 19) == 0);
      l = ($urandom_range(0, 7) == 0);
      e = 1'($urandom);
      d = 1'($urandom);
      s = 1'($urandom);
      m = 2'($urandom);
      p = 8'($urandom);
      sv = mq;
      mq = model(sv, c, l, p, e, d, m, s);
      step(c, l, p, e, d, m, s);
      eser = d ? mq[0] : mq[W-1];
      check($sformatf("rand%0d_q", n), par_out, mq);
      check($sformatf("rand%0d_ser", n), {7'd0, ser_out}, {7'd0, eser});
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/shift_reg.md
Name: shift_reg

Overview:
- Parameterised synchronous shift register with parallel load, serial input and output, direction control, and selectable fill mode (logical, arithmetic, rotate).
- General-purpose datapath utility for serialisers, deserialisers and bit-manipulation stages.
- Single clock domain.

Parameters:
- WIDTH, 8, register width in bits (must be ≥ 2).
- RESET_VALUE, 0, value loaded into the register on reset (WIDTH bits).

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- clr  input  1  synchronous clear: register becomes 0 on the next edge.
- load  input  1  synchronous parallel load of par_in.
- par_in  input  WIDTH  parallel load data.
- en  input  1  shift enable: one shift per clock while high.
- dir  input  1  shift direction: 0 = left (toward MSB), 1 = right (toward LSB).
- mode  input  2  fill mode: 00 logical, 01 arithmetic, 10 rotate, 11 hold.
- ser_in  input  1  serial input bit, used in logical mode.
- par_out  output  WIDTH  current register contents (direct register output).
- ser_out  output  1  bit that leaves on the next shift: q[WIDTH-1] when dir=0, q[0] when dir=1. Combinational from q and dir.

Behaviour:
- Reset: rst_n low forces q = RESET_VALUE immediately, without waiting for a clock edge. par_out = RESET_VALUE. ser_out follows q and dir.
- Release of rst_n is sampled at clock edges. The first update can occur on the first rising edge with rst_n high.
- Reset asserted mid-operation aborts any shift. No pending state remains.
- Per-edge priority, highest first: clr, then load, then en, then hold.
  - clr=1: q = 0, regardless of the other inputs.
  - load=1: q = par_in. en is ignored that cycle.
  - en=1: q is shifted by exactly one bit, as defined below.
  - Otherwise: q holds.
- Left shift (dir=0): q_next = {q[WIDTH-2:0], fill}.
- Right shift (dir=1): q_next = {fill, q[WIDTH-1:1]}.
- Fill bit by mode:
  - 00 logical: fill = ser_in.
  - 01 arithmetic, right: fill = q[WIDTH-1] (sign extension).
  - 01 arithmetic, left: fill = 0.
  - 10 rotate: fill = the bit shifted out (q[WIDTH-1] for left, q[0] for right). ser_in is ignored.
  - 11 hold: q unchanged even with en=1. Reserved encoding.
- Latency: par_out reflects a load or shift one clock after the edge that samples it, i.e. valid #DELAY after that rising edge. ser_out changes combinationally with dir.
- Boundaries:
  - WIDTH shifts in logical mode with ser_in=0 empty the register to 0.
  - WIDTH rotates in either direction return the original value.
  - Arithmetic right shift of a negative value saturates at all ones; of a positive value, at 0.
  - dir or mode may change every cycle. Each edge uses the values sampled at that edge.
- No X propagation from unused inputs: ser_in is ignored outside logical mode, par_in is ignored unless load=1.

Test Plan:
- Reset: drive rst_n=0 for 3 cycles with WIDTH=8 and RESET_VALUE=8'hA5 -> par_out=8'hA5 immediately after rst_n falls and during reset. Release -> value holds with en=0.
- Load and logical left: load 8'h81, then en=1, dir=0, mode=00, ser_in=1 for 3 cycles -> par_out sequence 8'h03, 8'h07, 8'h0F. ser_out before the first shift = 1.
- Arithmetic right: load 8'h90, dir=1, mode=01, en=1 for 4 cycles -> 8'hC8, 8'hE4, 8'hF2, 8'hF9. Load 8'h40 and shift twice -> 8'h20, 8'h10.
- Rotate: load 8'h96, dir=0, mode=10, 8 shifts -> first result 8'h2D, final 8'h96. Repeat with dir=1 -> first result 8'h4B, final 8'h96.
- Priority: with en=1, assert load=1, par_in=8'h3C -> 8'h3C, no shift. Assert clr=1 and load=1 together -> 8'h00. With mode=11 and en=1 -> value held.
- Async reset mid-shift: during continuous shifting, pull rst_n low between clock edges -> par_out=RESET_VALUE within #DELAY, before the next edge.
